// File: rtl/multiplier_arbiter_if.sv
// Purpose: bundles the client request/grant/done bus and the shared multiplier link.
// Latency: none (wiring only).
// Backpressure: clients hold i_request and operands until they see o_grant.
interface multiplier_arbiter_if #(
    parameter int N = 4,
    parameter int R = 4
);
    logic [R-1:0]   i_request;
    logic [R*N-1:0] i_multiplicand;
    logic [R*N-1:0] i_multiplier;
    logic [R-1:0]   o_grant;
    logic [R-1:0]   o_done;
    logic [2*N-1:0] o_product;
    logic           o_error;
    logic           o_busy;
    logic           o_mul_start;
    logic [N-1:0]   o_mul_multiplicand;
    logic [N-1:0]   o_mul_multiplier;
    logic           i_mul_finished;
    logic [2*N-1:0] i_mul_product;

    // Arbiter side: consumes requests and the multiplier result, drives everything else.
    modport slave (
        input  i_request, i_multiplicand, i_multiplier, i_mul_finished, i_mul_product,
        output o_grant, o_done, o_product, o_error, o_busy,
        output o_mul_start, o_mul_multiplicand, o_mul_multiplier
    );

    // Environment side: the clients plus the multiplier instance.
    modport master (
        output i_request, i_multiplicand, i_multiplier, i_mul_finished, i_mul_product,
        input  o_grant, o_done, o_product, o_error, o_busy,
        input  o_mul_start, o_mul_multiplicand, o_mul_multiplier
    );
endinterface

// File: rtl/multiplier_arbiter.sv
// Purpose: round-robin share of one sequential multiplier between R requesters.
// Latency: grant -> start 1 cycle, grant -> done >= 4 cycles; timeout aborts with o_error.
// Backpressure: requests are only sampled in IDLE; pending requests wait, never dropped.
module multiplier_arbiter #(
    parameter int N       = 4,
    parameter int R       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    multiplier_arbiter_if.slave  bus
);
    localparam int PW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

    state_t          state_q,   state_d;
    logic [PW-1:0]   ptr_q,     ptr_d;
    logic [PW-1:0]   owner_q,   owner_d;
    logic [CW-1:0]   cnt_q,     cnt_d;
    logic [N-1:0]    mcand_q,   mcand_d;
    logic [N-1:0]    mplier_q,  mplier_d;
    logic [2*N-1:0]  res_q,     res_d;
    logic            res_err_q, res_err_d;
    logic [R-1:0]    grant_q,   grant_d;
    logic            start_q,   start_d;
    logic [R-1:0]    done_q,    done_d;
    logic [2*N-1:0]  product_q, product_d;
    logic            error_q,   error_d;
    logic            busy_q,    busy_d;

    logic            found;
    logic [PW-1:0]   pick;

    // Round-robin search: first requesting index starting at ptr, wrapping past R-1.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 0; i < R; i++) begin
            int j;
            j = int'(ptr_q) + i;
            if (j >= R) begin
                j = j - R;
            end
            if (!found && bus.i_request[j]) begin
                found = 1'b1;
                pick  = PW'(j);
            end
        end
    end

    // Next-state logic. Pulse outputs are computed from the current state and
    // registered, so each appears on the bus one cycle after its decision.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        res_d     = res_q;
        res_err_d = res_err_q;
        grant_d   = '0;
        start_d   = 1'b0;
        done_d    = '0;
        product_d = '0;
        error_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    owner_d  = pick;
                    mcand_d  = bus.i_multiplicand[int'(pick)*N +: N];
                    mplier_d = bus.i_multiplier[int'(pick)*N +: N];
                    grant_d  = R'(1) << pick;
                    state_d  = S_START;
                end
            end
            S_START: begin
                start_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // cnt_q == 0 marks the first WAIT cycle, where the finished flag
                // may still be left over from the previous operation.
                if (cnt_q != '0 && bus.i_mul_finished) begin
                    res_d     = bus.i_mul_product;
                    res_err_d = 1'b0;
                    state_d   = S_DONE;
                end else if (TIMEOUT != 0 && cnt_q == CW'(TIMEOUT)) begin
                    res_d     = '0;
                    res_err_d = 1'b1;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                done_d    = R'(1) << owner_q;
                product_d = res_q;
                error_d   = res_err_q;
                ptr_d     = (owner_q == PW'(R - 1)) ? '0 : owner_q + 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Busy tracks the FSM state itself (high from the grant cycle through DONE).
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            res_q     <= '0;
            res_err_q <= 1'b0;
            grant_q   <= '0;
            start_q   <= 1'b0;
            done_q    <= '0;
            product_q <= '0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            res_q     <= res_d;
            res_err_q <= res_err_d;
            grant_q   <= grant_d;
            start_q   <= start_d;
            done_q    <= done_d;
            product_q <= product_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.o_grant            = grant_q;
    assign bus.o_done             = done_q;
    assign bus.o_product          = product_q;
    assign bus.o_error            = error_q;
    assign bus.o_busy             = busy_q;
    assign bus.o_mul_start        = start_q;
    assign bus.o_mul_multiplicand = mcand_q;
    assign bus.o_mul_multiplier   = mplier_q;
endmodule

// File: tb/tb_multiplier_arbiter.sv
// Purpose: scoreboard bench for multiplier_arbiter with a latency-programmable multiplier model.
// Latency: expected start-to-done latency carried per transaction.
// Backpressure: client drivers hold requests until granted.
module tb_multiplier_arbiter;
    localparam int N  = 4;
    localparam int R  = 4;
    localparam int TO = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    multiplier_arbiter_if #(.N(N), .R(R)) bus();

    multiplier_arbiter #(.N(N), .R(R), .TIMEOUT(TO)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [R-1:0]   who;
        logic [2*N-1:0] prod;
        logic           err;
        int             lat;
    } exp_t;

    exp_t         exp_q[$];
    logic [R-1:0] gnt_q[$];
    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           pend[R] = '{default: 0};
    logic [N-1:0] a_op[R] = '{default: '0};
    logic [N-1:0] b_op[R] = '{default: '0};
    int           mdl_lat  = 1;
    bit           mdl_hang = 1'b0;
    int           grant_cyc = -100;
    int           start_cyc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_op(input int k, input int p, input bit e, input int lat);
        exp_t x;
        x.who  = R'(1) << k;
        x.prod = (2*N)'(p);
        x.err  = e;
        x.lat  = lat;
        gnt_q.push_back(R'(1) << k);
        exp_q.push_back(x);
    endtask

    function automatic bit pend_any();
        bit r;
        r = 1'b0;
        for (int k = 0; k < R; k++) begin
            if (pend[k] > 0) r = 1'b1;
        end
        return r;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0 || pend_any()) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, {bus.o_grant, bus.o_done, bus.o_error, bus.o_busy, bus.o_mul_start}, 0);
        check({name, "_prod"}, bus.o_product, 0);
        check({name, "_ops"}, {bus.o_mul_multiplicand, bus.o_mul_multiplier}, 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Client drivers: each requester keeps asking while it has operations pending.
    initial begin
        bus.i_request      = '0;
        bus.i_multiplicand = '0;
        bus.i_multiplier   = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < R; k++) begin
                if (bus.o_grant[k] && pend[k] > 0) pend[k]--;
                bus.i_request[k]          = (pend[k] > 0);
                bus.i_multiplicand[k*N +: N] = a_op[k];
                bus.i_multiplier[k*N +: N]   = b_op[k];
            end
        end
    end

    // Multiplier model: finished goes low on start, high mdl_lat negedges later.
    initial begin
        logic [N-1:0] ma;
        logic [N-1:0] mb;
        int           cnt;
        bit           run;
        ma = '0; mb = '0; cnt = 0; run = 1'b0;
        bus.i_mul_finished = 1'b0;
        bus.i_mul_product  = '0;
        forever begin
            @(negedge clk);
            if (bus.o_mul_start) begin
                ma  = bus.o_mul_multiplicand;
                mb  = bus.o_mul_multiplier;
                cnt = mdl_lat;
                run = !mdl_hang;
                bus.i_mul_finished = 1'b0;
            end else if (run) begin
                cnt--;
            end
            if (run && cnt <= 0) begin
                bus.i_mul_finished = 1'b1;
                bus.i_mul_product  = {{N{1'b0}}, ma} * {{N{1'b0}}, mb};
                run = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT grants, starts or completes.
    initial begin
        logic [R-1:0] pd;
        exp_t         e;
        pd = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pd = '0;
                continue;
            end
            if (bus.o_grant != '0) begin
                grant_cyc = cyc;
                if (gnt_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_grant actual=%b required=none", bus.o_grant);
                end else begin
                    check("grant", bus.o_grant, gnt_q.pop_front());
                end
            end
            if (bus.o_mul_start) begin
                check("grant_to_start", cyc - grant_cyc, 1);
                start_cyc = cyc;
            end
            if (bus.o_done != '0) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_done actual=%b required=none", bus.o_done);
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", bus.o_done, e.who);
                    check("product", bus.o_product, e.prod);
                    check("error", bus.o_error, e.err);
                    if (e.lat >= 0) check("start_to_done", cyc - start_cyc, e.lat);
                end
            end else if (pd != '0) begin
                check("result_cleared", {bus.o_error, bus.o_product}, 0);
            end
            pd = bus.o_done;
        end
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_not_busy", bus.o_busy, 0);

        // 1: single request k=2, 3*5
        mdl_lat = 1; a_op[2] = 4'd3; b_op[2] = 4'd5;
        expect_op(2, 15, 1'b0, 3);
        pend[2] = 1;
        drain("t1_drain", 40);

        // 2: max operands on k=0, slower multiplier
        mdl_lat = 4; a_op[0] = 4'd15; b_op[0] = 4'd15;
        expect_op(0, 225, 1'b0, 6);
        pend[0] = 1;
        drain("t2_drain", 40);

        // 3: after reset, 0 and 3 together -> 0 first, then 3
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_lat = 1;
        a_op[0] = 4'd7;  b_op[0] = 4'd9;
        a_op[3] = 4'd12; b_op[3] = 4'd11;
        expect_op(0, 63, 1'b0, 3);
        expect_op(3, 132, 1'b0, 3);
        pend[0] = 1; pend[3] = 1;
        drain("t3_drain", 60);

        // 4: all four held for 8 ops; zero-latency model also exercises the stale-flag guard
        mdl_lat = 0;
        a_op[0] = 4'd2;  b_op[0] = 4'd3;
        a_op[1] = 4'd4;  b_op[1] = 4'd5;
        a_op[2] = 4'd6;  b_op[2] = 4'd7;
        a_op[3] = 4'd15; b_op[3] = 4'd14;
        for (int r = 0; r < 2; r++) begin
            expect_op(0, 6, 1'b0, 3);
            expect_op(1, 20, 1'b0, 3);
            expect_op(2, 42, 1'b0, 3);
            expect_op(3, 210, 1'b0, 3);
        end
        for (int k = 0; k < R; k++) pend[k] = 2;
        drain("t4_drain", 200);

        // 5: multiplier never finishes -> timeout abort
        mdl_hang = 1'b1;
        a_op[1] = 4'd2; b_op[1] = 4'd3;
        expect_op(1, 0, 1'b1, 66);
        pend[1] = 1;
        drain("t5_drain", 200);

        // 6: move ptr to 3, then reset during WAIT; ptr must restart at 0
        mdl_hang = 1'b0; mdl_lat = 1;
        a_op[2] = 4'd1; b_op[2] = 4'd1;
        expect_op(2, 1, 1'b0, 3);
        pend[2] = 1;
        drain("t6_pre_drain", 40);
        mdl_hang = 1'b1;
        a_op[0] = 4'd5; b_op[0] = 4'd5;
        gnt_q.push_back(4'b0001);
        pend[0] = 1;
        n = 0;
        while (!bus.o_mul_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_started", bus.o_mul_start, 1);
        repeat (3) @(negedge clk);
        check("t6_busy_in_wait", bus.o_busy, 1);
        rst = 1'b1;
        #1;
        check_outputs_zero("t6_reset");
        check("t6_grant_seen", gnt_q.size(), 0);
        gnt_q.delete();
        exp_q.delete();
        for (int k = 0; k < R; k++) pend[k] = 0;
        mdl_hang = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        a_op[1] = 4'd9; b_op[1] = 4'd8;
        a_op[3] = 4'd3; b_op[3] = 4'd4;
        expect_op(1, 72, 1'b0, 3);
        expect_op(3, 12, 1'b0, 3);
        pend[1] = 1; pend[3] = 1;
        drain("t6_drain", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
